// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon keypad front end.
package simon_pkg;

   localparam int NUM_KEYS = 4;
   localparam int KEY_W    = 2;

   typedef enum logic [1:0] {IDLE, PRESSED, CHORD} keypad_state_t;

   function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
      return (v != '0) && ((v & (v - {{(NUM_KEYS-1){1'b0}}, 1'b1})) == '0);
   endfunction

   function automatic logic [KEY_W-1:0] key_index(input logic [NUM_KEYS-1:0] v);
      logic [KEY_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (v[i]) idx = KEY_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/simon_keypad_if.sv
// Keypad bus: raw buttons and timebase in, clean key level/events out.
interface simon_keypad_if;
   import simon_pkg::*;

   logic [15:0]         ticks_per_milli;
   logic [NUM_KEYS-1:0] btn_raw;
   logic [NUM_KEYS-1:0] btn;
   logic                key_valid;
   logic [KEY_W-1:0]    key_code;
   logic                key_held;
   logic                multi_err;

   modport master (
      input  ticks_per_milli, btn_raw,
      output btn, key_valid, key_code, key_held, multi_err
   );

   modport slave (
      output ticks_per_milli, btn_raw,
      input  btn, key_valid, key_code, key_held, multi_err
   );

endinterface

// File: rtl/simon_debounce.sv
// One-button synchroniser and ms-based debouncer; stable follows sync after DEBOUNCE_MS ticks.
module simon_debounce #(
   parameter int DEBOUNCE_MS = 20,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ms_tick,
   input  logic raw,
   output logic stable
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [7:0]             cnt_q;
   logic                   sync_bit;

   assign sync_bit = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         stable <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         // Any return to the accepted level restarts the hold count.
         if (sync_bit == stable) begin
            cnt_q <= '0;
         end else if (ms_tick) begin
            if (cnt_q == 8'(DEBOUNCE_MS - 1)) begin
               stable <= sync_bit;
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + 8'd1;
            end
         end
      end
   end

endmodule

// File: rtl/simon_keypad.sv
// Keypad front end: ms tick, 4 debouncers, press/chord FSM with registered outputs.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module simon_keypad
   import simon_pkg::*;
#(
   parameter int DEBOUNCE_MS = 20,
   parameter int SYNC_STAGES = 2
`ifdef KEY_REPEAT_EN
   ,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 200
`endif
) (
   input logic           clk,
   input logic           rst_n,
   simon_keypad_if.master kp
);

   logic [15:0]         tick_cnt_q;
   logic                ms_tick;
   logic [NUM_KEYS-1:0] stable;

   keypad_state_t       state_q, state_d;
   logic [NUM_KEYS-1:0] btn_q, btn_d;
   logic                key_valid_q, key_valid_d;
   logic [KEY_W-1:0]    key_code_q, key_code_d;
   logic                multi_err_q, multi_err_d;
   logic                rep_fire;

   // Live compare: a shrinking divisor below the count lets it wrap at 16 bits.
   assign ms_tick = (tick_cnt_q == kp.ticks_per_milli);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tick_cnt_q <= '0;
      else        tick_cnt_q <= ms_tick ? 16'd0 : tick_cnt_q + 16'd1;
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
      simon_debounce #(
         .DEBOUNCE_MS (DEBOUNCE_MS),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_db (
         .clk     (clk),
         .rst_n   (rst_n),
         .ms_tick (ms_tick),
         .raw     (kp.btn_raw[i]),
         .stable  (stable[i])
      );
   end

`ifdef KEY_REPEAT_EN
   logic [15:0] rep_q, rep_d;

   // Counts ms while the same key stays held; cleared whenever PRESSED is not held.
   always_comb begin
      rep_d    = '0;
      rep_fire = 1'b0;
      if (state_q == PRESSED && stable == btn_q) begin
         rep_d = rep_q;
         if (ms_tick) begin
            rep_d = rep_q + 16'd1;
            if (rep_d == 16'(REPEAT_DELAY_MS)) begin
               rep_fire = 1'b1;
            end else if (rep_d == 16'(REPEAT_DELAY_MS + REPEAT_RATE_MS)) begin
               rep_fire = 1'b1;
               rep_d    = 16'(REPEAT_DELAY_MS);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rep_q <= '0;
      else        rep_q <= rep_d;
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      btn_d       = btn_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      multi_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (stable != '0) begin
               if (is_onehot(stable)) begin
                  state_d     = PRESSED;
                  key_valid_d = 1'b1;
                  key_code_d  = key_index(stable);
                  btn_d       = stable;
               end else begin
                  state_d     = CHORD;
                  multi_err_d = 1'b1;
               end
            end
         end
         PRESSED: begin
            if (stable == '0) begin
               state_d = IDLE;
               btn_d   = '0;
            end else if (stable != btn_q) begin
               state_d     = CHORD;
               btn_d       = '0;
               multi_err_d = 1'b1;
            end else begin
               key_valid_d = rep_fire;
            end
         end
         CHORD: begin
            btn_d = '0;
            if (stable == '0) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            btn_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         btn_q       <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         multi_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         btn_q       <= btn_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         multi_err_q <= multi_err_d;
      end
   end

   assign kp.btn       = btn_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_held  = (state_q == PRESSED);
   assign kp.multi_err = multi_err_q;

endmodule
